// File: rtl/moi_search_ctrl.sv
// -----------------------------------------------------------------------------
// moi_search_ctrl
//
// Sequential search controller. A single match-or-inverse comparator
// (entry == key or entry == ~key) is time-shared across a DEPTH-entry table:
// on an accepted start the latched key is compared against one table entry per
// clock, and the first valid hit (or a full miss) is reported with a one-cycle
// done pulse.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   wr_en      in   table write strobe (sets the entry's valid bit)
//   wr_addr    in   write index; indices >= DEPTH are ignored
//   wr_data    in   write data
//   clr_valid  in   clear all valid bits (a same-cycle write still lands valid)
//   start      in   begin a search, sampled in IDLE only
//   abort      in   cancel a search in progress; no done pulse, results held
//   key        in   search key, captured on an accepted start
//   busy       out  high while scanning
//   done       out  one-cycle pulse when a search completes
//   hit        out  a valid entry matched
//   hit_inv    out  the match was inverse (entry == ~key)
//   hit_idx    out  index of the first match (0 on a miss)
// -----------------------------------------------------------------------------
module moi_search_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              clr_valid,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  key,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic              hit_inv,
  output logic [ADDR_W-1:0] hit_idx
);

  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [WIDTH-1:0]   key_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic               busy_q, done_q, hit_q, hit_inv_q;
  logic [ADDR_W-1:0]  hit_idx_q;

  logic               wr_ok;
  logic [WIDTH-1:0]   cmp_entry;
  logic               cmp_exact, cmp_inv, cmp_hit;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_W);

  // ---------------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------------
  // NOTE: table data has no reset; the valid bits alone decide whether an
  // entry can ever be compared, so resetting the array would only add muxes.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Clear first, then set: a write coinciding with clr_valid stays valid.
  always_comb begin
    // NOTE: assign a default before any conditional update in combinational
    // logic, otherwise paths that skip an assignment infer a latch.
    valid_d = valid_q;
    if (clr_valid) begin
      valid_d = '0;
    end
    if (wr_ok) begin
      valid_d[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      // NOTE: sequential state is always updated with non-blocking
      // assignments so every flop samples pre-edge values.
      valid_q <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // The single shared comparator. It reads the table as it stands during the
  // current cycle, so a write landing on the entry under compare only becomes
  // visible if that entry is revisited (it never is).
  // ---------------------------------------------------------------------------
  always_comb begin
    cmp_entry = mem_q[idx_q];
    cmp_exact = (cmp_entry == key_q);
    cmp_inv   = (cmp_entry == ~key_q);
    cmp_hit   = valid_q[idx_q] && (cmp_exact || cmp_inv);
  end

  // ---------------------------------------------------------------------------
  // Search FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      key_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      hit_inv_q <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            key_q   <= key;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // abort wins over a same-cycle hit and leaves the results untouched.
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (cmp_hit) begin
            // Exact and inverse are exclusive, so !exact means inverse here.
            hit_q     <= 1'b1;
            hit_inv_q <= !cmp_exact;
            hit_idx_q <= idx_q;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end else if (idx_q == LAST_IDX) begin
            hit_q     <= 1'b0;
            hit_inv_q <= 1'b0;
            hit_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        ST_DONE: begin
          // start is deliberately not sampled here: next accept is from IDLE.
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hit     = hit_q;
  assign hit_inv = hit_inv_q;
  assign hit_idx = hit_idx_q;

endmodule

// File: tb/tb_moi_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_moi_search_ctrl
//
// Self-checking bench for moi_search_ctrl. A timeline model (cycle numbers,
// start cycle, computed done cycle) predicts every output on every cycle, a
// snapshot scoreboard predicts each random search's result and latency, and
// directed scenarios pin both with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_moi_search_ctrl;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [WIDTH-1:0]  wr_data = '0;
  logic              clr_valid = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [WIDTH-1:0]  key = '0;
  logic              busy, done, hit, hit_inv;
  logic [ADDR_W-1:0] hit_idx;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  moi_search_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_valid(clr_valid),
    .start    (start),
    .abort    (abort),
    .key      (key),
    .busy     (busy),
    .done     (done),
    .hit      (hit),
    .hit_inv  (hit_inv),
    .hit_idx  (hit_idx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Timeline model: cycle c is the cycle ending at the c-th rising edge after
  // reset. A start seen at the end of cycle s makes entry k compared in cycle
  // s+1+k; the search finishes with done in the cycle after the deciding one.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic [DEPTH-1:0] m_valid;
  logic [WIDTH-1:0] m_key;
  bit               m_active;
  int               m_cyc, m_s, m_done_cyc, m_idx;
  bit               m_hit, m_inv;

  function automatic bit match_at(input int k);
    return m_valid[k] && ((m_mem[k] == m_key) || (m_mem[k] == ~m_key));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= '0;
      m_key      <= '0;
      m_active   <= 1'b0;
      m_cyc      <= 0;
      m_s        <= 0;
      m_done_cyc <= -1;
      m_hit      <= 1'b0;
      m_inv      <= 1'b0;
      m_idx      <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (clr_valid) m_valid <= '0;
      if (wr_en && int'(wr_addr) < DEPTH) begin
        m_mem[wr_addr]   <= wr_data;
        m_valid[wr_addr] <= 1'b1;
      end
      if (!m_active) begin
        if (start && m_cyc != m_done_cyc) begin
          m_active <= 1'b1;
          m_s      <= m_cyc;
          m_key    <= key;
        end
      end else if (abort) begin
        m_active <= 1'b0;
      end else if (match_at(m_cyc - m_s - 1)) begin
        m_active   <= 1'b0;
        m_done_cyc <= m_cyc + 1;
        m_hit      <= 1'b1;
        m_inv      <= (m_mem[m_cyc - m_s - 1] != m_key);
        m_idx      <= m_cyc - m_s - 1;
      end else if (m_cyc - m_s - 1 == DEPTH - 1) begin
        m_active   <= 1'b0;
        m_done_cyc <= m_cyc + 1;
        m_hit      <= 1'b0;
        m_inv      <= 1'b0;
        m_idx      <= 0;
      end
    end
  end

  // Every cycle out of reset, all outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cycle_outputs", {busy, done, hit, hit_inv, hit_idx},
            {m_active, (m_cyc == m_done_cyc), m_hit, m_inv, ADDR_W'(m_idx)});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change just after a falling edge)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sb_mem [DEPTH];
  logic [DEPTH-1:0] sb_valid = '0;

  task automatic wr(input int a, input logic [WIDTH-1:0] d, input bit clr);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d; clr_valid = clr;
    @(negedge clk);
    wr_en = 1'b0; clr_valid = 1'b0;
    if (clr) sb_valid = '0;
    sb_mem[a]   = d;
    sb_valid[a] = 1'b1;
  endtask

  task automatic clr();
    clr_valid = 1'b1;
    @(negedge clk);
    clr_valid = 1'b0;
    sb_valid = '0;
  endtask

  // Runs one search; optional writes at cycles wc_a / wc_b (cycle 1 = first
  // busy cycle). lat is the cycle of the done pulse, -1 if it never came.
  // Returns in the IDLE cycle after done so the next start is accepted.
  task automatic search(input logic [WIDTH-1:0] k,
                        input int wc_a, input int wa_a, input logic [WIDTH-1:0] wd_a,
                        input int wc_b, input int wa_b, input logic [WIDTH-1:0] wd_b,
                        output int lat);
    key = k; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= DEPTH + 4; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      wr_en = 1'b0;
      if (n == wc_a) begin wr_en = 1'b1; wr_addr = ADDR_W'(wa_a); wr_data = wd_a; end
      if (n == wc_b) begin wr_en = 1'b1; wr_addr = ADDR_W'(wa_b); wr_data = wd_b; end
      @(negedge clk);
    end
    wr_en = 1'b0;
    if (lat < 0) check("search_done_seen", done, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    int lat, dones, exp_k;
    logic [WIDTH-1:0] rk, d;
    int a, sel;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, hit, hit_inv, hit_idx}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty table: full miss, done at cycle 1+DEPTH
    search(8'h3C, -1, 0, 8'h00, -1, 0, 8'h00, lat);
    check("empty_latency", lat, 17);
    check("empty_hit", {hit, hit_inv, hit_idx}, 32'h0);

    // Inverse hit at entry 5
    wr(5, 8'hC3, 1'b0);
    search(8'h3C, -1, 0, 8'h00, -1, 0, 8'h00, lat);
    check("inv5_latency", lat, 7);
    check("inv5_result", {hit, hit_inv, hit_idx}, {1'b1, 1'b1, 4'd5});

    // First match wins; then clr_valid + rewrite of entry 9 in one cycle
    clr();
    wr(2, 8'hC3, 1'b0);
    wr(9, 8'h3C, 1'b0);
    search(8'h3C, -1, 0, 8'h00, -1, 0, 8'h00, lat);
    check("first_latency", lat, 4);
    check("first_result", {hit, hit_inv, hit_idx}, {1'b1, 1'b1, 4'd2});
    wr(9, 8'h3C, 1'b1);
    search(8'h3C, -1, 0, 8'h00, -1, 0, 8'h00, lat);
    check("exact9_latency", lat, 11);
    check("exact9_result", {hit, hit_inv, hit_idx}, {1'b1, 1'b0, 4'd9});

    // Abort in cycle 5; a start pulse during SCAN is ignored
    clr();
    wr(12, 8'h5A, 1'b0);
    key = 8'h5A; start = 1'b1;
    @(negedge clk);                        // cycle 1
    start = 1'b0;
    check("abort_busy_c1", busy, 1'b1);
    @(negedge clk);                        // cycle 2
    start = 1'b1;
    @(negedge clk);                        // cycle 3
    start = 1'b0;
    @(negedge clk);                        // cycle 4
    @(negedge clk);                        // cycle 5
    abort = 1'b1;
    check("abort_busy_c5", busy, 1'b1);
    @(negedge clk);                        // cycle 6
    abort = 1'b0;
    check("abort_busy_c6", busy, 1'b0);
    dones = 0;
    for (int n = 0; n < 20; n++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("abort_no_done", dones, 0);
    check("abort_results_held", {hit, hit_inv, hit_idx}, {1'b1, 1'b0, 4'd9});

    // Writes during SCAN: entry 4 rewritten while compared, entry 10 ahead
    clr();
    wr(4, 8'h11, 1'b0);
    search(8'h77, 5, 4, 8'h77, 7, 10, 8'h77, lat);
    check("scanwr_latency", lat, 12);
    check("scanwr_result", {hit, hit_inv, hit_idx}, {1'b1, 1'b0, 4'd10});

    // Asynchronous reset in the middle of a search
    clr();
    key = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midreset_outputs", {busy, done, hit, hit_inv, hit_idx}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sb_valid = '0;
    @(negedge clk);

    // Random searches against the snapshot scoreboard
    for (int i = 0; i < 5000; i++) begin
      rk = WIDTH'($urandom);
      if ($urandom_range(7) == 0) clr();
      repeat ($urandom_range(2)) begin
        a   = $urandom_range(DEPTH - 1);
        sel = $urandom_range(3);
        d   = (sel == 0) ? rk : (sel == 1) ? ~rk : WIDTH'($urandom);
        wr(a, d, 1'b0);
      end
      exp_k = -1;
      for (int j = 0; j < DEPTH; j++) begin
        if (sb_valid[j] && (sb_mem[j] == rk || sb_mem[j] == ~rk)) begin
          exp_k = j;
          break;
        end
      end
      search(rk, -1, 0, 8'h00, -1, 0, 8'h00, lat);
      if (exp_k >= 0) begin
        check("rand_latency", lat, 2 + exp_k);
        check("rand_result", {hit, hit_inv, hit_idx},
              {1'b1, (sb_mem[exp_k] != rk), ADDR_W'(exp_k)});
      end else begin
        check("rand_latency", lat, 1 + DEPTH);
        check("rand_result", {hit, hit_inv, hit_idx}, 32'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
